digital_lock: RTL and testbench

//   4-bit combination lock with a single status LED. Samples a 4-bit code every

---
 rtl/digital_lock.sv | 101 ++++++++++
 tb/tb_digital_lock.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/digital_lock.sv
// 4-bit combination lock: unlocks on the fixed secret, counts failed retries
// and latches into a permanent lockout once the retry budget is spent.
module digital_lock #(
    parameter logic [3:0] SECRET    = 4'b1010,
    parameter logic [3:0] MAX_FAILS = 4'd3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       try_again,
    input  logic [3:0] password,
    output logic       led_output
);

    typedef enum logic [1:0] {
        LOCKED    = 2'b00,
        TRY_AGAIN = 2'b01,
        UNLOCKED  = 2'b10,
        LOCKOUT   = 2'b11
    } state_t;

    state_t     state_r;
    logic [3:0] fail_cnt_r;
    logic       match_s;
    logic [3:0] fail_next_s;

    // Saturating increment: the counter stops at the lockout threshold.
    function automatic logic [3:0] sat_inc(input logic [3:0] value, input logic [3:0] limit);
        logic [3:0] result;
        if (value < limit) begin
            result = value + 4'd1;
        end else begin
            result = limit;
        end
        return result;
    endfunction

    assign match_s = (password == SECRET);

    // Failure count that would result if the current retry evaluation fails.
    always_comb begin
        fail_next_s = sat_inc(fail_cnt_r, MAX_FAILS);
    end

    // Lock FSM; the LED is registered from the next state so it tracks UNLOCKED exactly.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r    <= LOCKED;
            fail_cnt_r <= 4'd0;
            led_output <= 1'b0;
        end else begin
            case (state_r)
                LOCKED: begin
                    if (match_s) begin
                        state_r    <= UNLOCKED;
                        fail_cnt_r <= 4'd0;
                        led_output <= 1'b1;
                    end else if (try_again) begin
                        state_r    <= TRY_AGAIN;
                        led_output <= 1'b0;
                    end else begin
                        state_r    <= LOCKED;
                        led_output <= 1'b0;
                    end
                end
                TRY_AGAIN: begin
                    if (match_s) begin
                        state_r    <= UNLOCKED;
                        fail_cnt_r <= 4'd0;
                        led_output <= 1'b1;
                    end else begin
                        fail_cnt_r <= fail_next_s;
                        led_output <= 1'b0;
                        if (fail_next_s == MAX_FAILS) begin
                            state_r <= LOCKOUT;
                        end else begin
                            state_r <= LOCKED;
                        end
                    end
                end
                UNLOCKED: begin
                    if (match_s) begin
                        state_r    <= UNLOCKED;
                        led_output <= 1'b1;
                    end else begin
                        state_r    <= LOCKED;
                        led_output <= 1'b0;
                    end
                end
                LOCKOUT: begin
                    state_r    <= LOCKOUT;
                    led_output <= 1'b0;
                end
                default: begin
                    state_r    <= LOCKED;
                    led_output <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_digital_lock.sv
// Scoreboard bench for digital_lock: each stimulus cycle queues the LED value
// expected after the next rising edge; a monitor pops and compares every cycle.
module tb_digital_lock;

    logic       clk;
    logic       reset;
    logic       try_again;
    logic [3:0] password;
    logic       led_output;

    int n_checks;
    int n_fails;
    bit exp_q[$];
    string name_q[$];

    digital_lock dut (
        .clk        (clk),
        .reset      (reset),
        .try_again  (try_again),
        .password   (password),
        .led_output (led_output)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Apply one cycle of inputs at the falling edge and queue the expected LED.
    task automatic step(input logic rst, input logic [3:0] pw, input logic ta,
                        input bit exp, input string name);
        @(negedge clk);
        reset     = rst;
        password  = pw;
        try_again = ta;
        exp_q.push_back(exp);
        name_q.push_back(name);
    endtask

    // Monitor: sample shortly after each rising edge and compare against the queue head.
    initial begin
        bit    e;
        string nm;
        forever begin
            @(posedge clk);
            #2;
            if (exp_q.size() > 0) begin
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                n_checks++;
                if (led_output !== e) begin
                    n_fails++;
                    $display("FAIL %s: led_output got %b expected %b at %0t", nm, led_output, e, $time);
                end
            end
        end
    end

    initial begin
        int budget;
        n_checks  = 0;
        n_fails   = 0;
        reset     = 1'b1;
        try_again = 1'b0;
        password  = 4'b0000;

        // 1: reset held two clocks, then wrong code idles locked
        step(1'b1, 4'b0000, 1'b0, 1'b0, "reset_hold0");
        step(1'b1, 4'b0000, 1'b0, 1'b0, "reset_hold1");
        for (int i = 0; i < 4; i++) step(1'b0, 4'b0000, 1'b0, 1'b0, "idle_locked");

        // 2: one failed retry
        step(1'b0, 4'b0011, 1'b1, 1'b0, "enter_try_again");
        step(1'b0, 4'b0011, 1'b0, 1'b0, "retry_fail1");
        step(1'b0, 4'b0011, 1'b0, 1'b0, "back_locked");

        // 3: secret unlocks one edge later and holds
        step(1'b0, 4'b1010, 1'b0, 1'b1, "unlock");
        step(1'b0, 4'b1010, 1'b0, 1'b1, "unlock_hold");

        // 4: relock on code change, try_again ignored in UNLOCKED, then retry fail and unlock
        step(1'b0, 4'b1100, 1'b1, 1'b0, "relock_ignore_ta");
        step(1'b0, 4'b1100, 1'b1, 1'b0, "enter_try_again2");
        step(1'b0, 4'b1100, 1'b0, 1'b0, "retry_fail2");
        step(1'b0, 4'b1010, 1'b0, 1'b1, "unlock_again");
        // retry that succeeds: two-edge path
        step(1'b0, 4'b0000, 1'b0, 1'b0, "relock2");
        step(1'b0, 4'b0000, 1'b1, 1'b0, "enter_try_again3");
        step(1'b0, 4'b1010, 1'b0, 1'b1, "retry_match_unlock");
        // match has priority over try_again in LOCKED
        step(1'b0, 4'b0000, 1'b0, 1'b0, "relock3");
        step(1'b0, 4'b1010, 1'b1, 1'b1, "match_priority");
        step(1'b0, 4'b1010, 1'b0, 1'b1, "match_priority_hold");

        // fail count clears on unlock: 2 fails, unlock, 2 fails, still unlockable
        step(1'b0, 4'b0000, 1'b0, 1'b0, "relock4");
        for (int i = 0; i < 2; i++) begin
            step(1'b0, 4'b0000, 1'b1, 1'b0, "ta_a");
            step(1'b0, 4'b0000, 1'b0, 1'b0, "fail_a");
        end
        step(1'b0, 4'b1010, 1'b0, 1'b1, "unlock_clears_cnt");
        step(1'b0, 4'b0000, 1'b0, 1'b0, "relock5");
        for (int i = 0; i < 2; i++) begin
            step(1'b0, 4'b0000, 1'b1, 1'b0, "ta_b");
            step(1'b0, 4'b0000, 1'b0, 1'b0, "fail_b");
        end
        step(1'b0, 4'b1010, 1'b0, 1'b1, "unlock_after_two_fails");

        // 5: three failed retries -> lockout, secret ignored
        step(1'b0, 4'b0000, 1'b0, 1'b0, "relock6");
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 4'b0000, 1'b1, 1'b0, "ta_c");
            step(1'b0, 4'b0000, 1'b0, 1'b0, "fail_c");
        end
        for (int i = 0; i < 4; i++) step(1'b0, 4'b1010, 1'b0, 1'b0, "lockout_secret");
        step(1'b0, 4'b1010, 1'b1, 1'b0, "lockout_ta");
        step(1'b0, 4'b1010, 1'b0, 1'b0, "lockout_hold");
        step(1'b1, 4'b1010, 1'b0, 1'b0, "reset_from_lockout");
        step(1'b0, 4'b1010, 1'b0, 1'b1, "unlock_after_reset");
        step(1'b0, 4'b1010, 1'b0, 1'b1, "unlock_after_reset_hold");

        // 6: asynchronous reset mid-cycle while UNLOCKED
        step(1'b0, 4'b1010, 1'b0, 1'b0, "async_reset_cycle");
        #2;
        reset = 1'b1;
        #1;
        n_checks++;
        if (led_output !== 1'b0) begin
            n_fails++;
            $display("FAIL async_reset: led_output got %b expected 0 at %0t", led_output, $time);
        end
        step(1'b0, 4'b1010, 1'b0, 1'b1, "unlock_after_async_reset");
        step(1'b0, 4'b0101, 1'b0, 1'b0, "final_relock");

        budget = 0;
        while (exp_q.size() > 0 && budget < 20) begin
            @(posedge clk);
            budget++;
        end
        #5;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fails++;
            $display("FAIL drain: %0d entries left expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
